tx_link_ctrl: RTL and testbench
===============================

# tx_link_ctrl

Transmit-side JESD204B link-layer controller, directly upstream of the TX link layer. Runs the local frame/multiframe (LMFC) counters and the CGS → ILAS → DATA state machine from the receiver's SYNC~. Drives the link-layer stream select and the frame position at SYNC~ de-assertion. Generates the complete ILA octet stream that the link layer muxes into its 8b/10b encoder.

## Interface
- F, 1, octets per frame (1..16)
- K, 32, frames per multiframe (1..32); F*K must be ≥ 17
- ILA_MF, 4, multiframes in ILA sequence (≥ 2)
- SYNC_REQ_FRAMES, 5, consecutive SYNC~-low frames that constitute a resync request
- clk  in  1  character clock; one clock domain
- rst  in  1  synchronous, active-high reset
- i_sync_n  in  1  SYNC~ from receiver, already synchronised to clk; low = request/error
- i_cfg  in  112  ILA link configuration octets; octet n = i_cfg[8n+7:8n], n = 0..13
- o_link_mux  out  3  stream select: 0 user data, 1 continuous K, 2 ILA
- o_ila_data  out  8  ILA octet, HGFEDCBA
- o_ila_vld  out  1  ILA octet valid
- o_ila_k  out  1  ILA octet is a control character
- o_no_frame_de_assertion  out  5  frame index within multiframe when SYNC~ de-asserted
- o_lmfc  out  1  one-cycle pulse on the first octet of every multiframe
- o_sync_err  out  1  one-cycle pulse: SYNC~ low pulse shorter than resync threshold
- o_state  out  2  0 CGS, 1 ILAS, 2 DATA

## Operation
- Counters: octet_cnt 0..F-1 and frame_cnt 0..K-1, free-running from reset. octet_cnt wraps to 0 and increments frame_cnt; frame_cnt wraps to 0. mf_pos = frame_cnt*F + octet_cnt. o_lmfc = 1 when mf_pos = 0.
- CGS: o_link_mux = 1. While i_sync_n = 1, an ILAS start is pending. At the first cycle of CGS with i_sync_n = 1, frame_cnt is captured into o_no_frame_de_assertion. If i_sync_n returns to 0 before the boundary, the pending start is cancelled and stays in CGS. Transition to ILAS on the edge ending a cycle with i_sync_n = 1 and mf_pos = F*K-1, so ILAS always begins at mf_pos = 0.
- ILAS: o_link_mux = 2, o_ila_vld = 1. An ILA multiframe index ila_mf counts 0..ILA_MF-1. Octet content, in priority order:
  - mf_pos = 0: 0x1C /R/, k = 1
  - mf_pos = F*K-1: 0x7C /A/, k = 1
  - ila_mf = 1 and mf_pos = 1: 0x9C /Q/, k = 1
  - ila_mf = 1 and mf_pos = 2..15: i_cfg octet mf_pos-2, k = 0
  - otherwise: mf_pos[7:0], k = 0
- After the last octet of ila_mf = ILA_MF-1, move to DATA; o_link_mux = 0, o_ila_vld/data/k = 0.
- Resync: in ILAS or DATA, a low counter counts consecutive i_sync_n = 0 cycles. On reaching SYNC_REQ_FRAMES*F, the next cycle is CGS. The counter clears when i_sync_n = 1. If i_sync_n rises with low count in 1..threshold-1, o_sync_err pulses for one cycle and the state is unchanged.
- Widths: mf_pos 9 bits; low counter 8 bits, saturating.

## Timing
- Reset values: o_link_mux = 1, o_ila_data = 0, o_ila_vld = 0, o_ila_k = 0, o_no_frame_de_assertion = 0, o_lmfc = 0, o_sync_err = 0, o_state = 0. Counters and ila_mf = 0.
- All outputs are registered. o_link_mux and o_ila_* update on the same edge, so the link layer's registered mux captures a matching select and octet.
- The first ILAS cycle outputs /R/ with o_link_mux = 2 together. The first DATA cycle has o_link_mux = 0.
- rst mid-ILAS/DATA: next cycle is CGS with reset values and counters at 0.
- i_sync_n falling in the same cycle as the ILAS→DATA transition: the transition occurs, and low counting continues in DATA.

## Structure
- Shared tx_link_pkg holds:
  - control-character constants K28_0 = 0x1C, K28_3 = 0x7C, K28_4 = 0x9C
  - state encoding CGS/ILAS/DATA
  - mux select codes MUX_USER/MUX_KSEQ/MUX_ILA
- One sub-module, lmfc_counter: octet_cnt/frame_cnt/mf_pos/last-octet/lmfc pulse, parameterised by F, K. FSM and ILA octet generation stay in the top.

## Test plan
- Reset with i_sync_n = 0 for 100 cycles -> o_state = 0, o_link_mux = 1, o_lmfc pulses every F*K cycles, o_ila_vld = 0.
- F = 1, K = 32, i_sync_n rises at frame_cnt = 7 -> o_no_frame_de_assertion = 7, ILAS starts 25 cycles later at mf_pos 0 with o_ila_data = 0x1C, k = 1.
- Full ILAS with i_cfg octet n = 0xA0+n -> MF1: octet 0 = 0x1C, octet 1 = 0x9C, octets 2..15 = 0xA0..0xAD, octet 31 = 0x7C; other octets = mf_pos; DATA after 128 octets.
- In DATA, F = 2, i_sync_n low 10 cycles -> CGS on cycle 11, o_link_mux = 1.
- In DATA, i_sync_n low 3 cycles -> single o_sync_err pulse, o_state stays 2.
- rst asserted during ILA multiframe 2 -> all outputs at reset values next cycle; re-entry to ILAS requires a new boundary.

Source files
------------

// File: rtl/tx_link_pkg.sv
// Shared definitions for the JESD204B transmit link controller:
// control characters, link state encoding and link-layer stream select codes.
package tx_link_pkg;

  // Control characters used in the ILA sequence
  localparam logic [7:0] K28_0 = 8'h1C;  // /R/ multiframe start
  localparam logic [7:0] K28_3 = 8'h7C;  // /A/ multiframe end
  localparam logic [7:0] K28_4 = 8'h9C;  // /Q/ configuration marker

  // Link state, visible on o_state
  typedef enum logic [1:0] {
    ST_CGS  = 2'd0,
    ST_ILAS = 2'd1,
    ST_DATA = 2'd2
  } link_state_e;

  // Link-layer stream select codes, visible on o_link_mux
  localparam logic [2:0] MUX_USER = 3'd0;
  localparam logic [2:0] MUX_KSEQ = 3'd1;
  localparam logic [2:0] MUX_ILA  = 3'd2;

endpackage

// File: rtl/lmfc_counter.sv
// Free-running local frame / multiframe counters. Supplies the frame index,
// the multiframe position of the next octet, a last-octet flag and a
// registered LMFC pulse aligned to the first octet of each multiframe.
module lmfc_counter #(
  parameter int F = 1,
  parameter int K = 32
) (
  input  logic       clk_i,
  input  logic       rst_i,
  output logic [4:0] frame_cnt_o,
  output logic [8:0] mf_pos_next_o,
  output logic       last_o,
  output logic       lmfc_o
);

  localparam logic [3:0] OCT_LAST = 4'(F - 1);
  localparam logic [4:0] FRM_LAST = 5'(K - 1);
  localparam logic [8:0] POS_LAST = 9'(F * K - 1);

  logic [3:0] octet_q, octet_d;
  logic [4:0] frame_q, frame_d;
  logic [8:0] mf_pos;
  logic       lmfc_q;

  assign mf_pos        = 9'(frame_q) * 9'(F) + 9'(octet_q);
  assign last_o        = (mf_pos == POS_LAST);
  assign mf_pos_next_o = last_o ? 9'd0 : mf_pos + 9'd1;
  assign frame_cnt_o   = frame_q;
  assign lmfc_o        = lmfc_q;

  // Next octet/frame position: octet wraps into frame, frame wraps at K
  always_comb begin
    octet_d = octet_q + 4'd1;
    frame_d = frame_q;
    if (octet_q == OCT_LAST) begin
      octet_d = 4'd0;
      frame_d = (frame_q == FRM_LAST) ? 5'd0 : frame_q + 5'd1;
    end
  end

  // Counter registers; the LMFC pulse is raised for the cycle following the last octet
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      octet_q <= 4'd0;
      frame_q <= 5'd0;
      lmfc_q  <= 1'b0;
    end else begin
      octet_q <= octet_d;
      frame_q <= frame_d;
      lmfc_q  <= last_o;
    end
  end

endmodule

// File: rtl/tx_link_ctrl.sv
// JESD204B transmit link-layer controller: CGS -> ILAS -> DATA sequencing
// from SYNC~, resync / short-pulse error detection, and generation of the
// ILA octet stream. All outputs are registered from next-state values so the
// stream select and the ILA octet change on the same edge.
module tx_link_ctrl
  import tx_link_pkg::*;
#(
  parameter int F               = 1,
  parameter int K               = 32,
  parameter int ILA_MF          = 4,
  parameter int SYNC_REQ_FRAMES = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_sync_n,
  input  logic [111:0] i_cfg,
  output logic [2:0]   o_link_mux,
  output logic [7:0]   o_ila_data,
  output logic         o_ila_vld,
  output logic         o_ila_k,
  output logic [4:0]   o_no_frame_de_assertion,
  output logic         o_lmfc,
  output logic         o_sync_err,
  output logic [1:0]   o_state
);

  localparam logic [8:0] POS_LAST = 9'(F * K - 1);
  localparam logic [7:0] ILA_LAST = 8'(ILA_MF - 1);
  localparam logic [7:0] LOW_THR  = 8'(SYNC_REQ_FRAMES * F);

  logic [4:0]  frame_cnt;
  logic [8:0]  mf_pos_next;
  logic        last_oct;
  logic        lmfc;

  link_state_e state_q, state_d;
  logic        pending_q, pending_d;
  logic [7:0]  low_q, low_d;
  logic [7:0]  ila_mf_q, ila_mf_d;
  logic [4:0]  nofr_q, nofr_d;
  logic        err_q, err_d;
  logic [2:0]  mux_q, mux_d;
  logic        vld_q, vld_d;
  logic [7:0]  data_q;
  logic        k_q;
  logic [8:0]  ila_d;

  // ILA octet {k, data} for a given multiframe position and ILA multiframe index
  function automatic logic [8:0] ila_octet(input logic [8:0]   pos,
                                           input logic [7:0]   mf,
                                           input logic [111:0] cfg);
    logic [8:0] r;
    int         idx;
    r = {1'b0, pos[7:0]};
    if (pos == 9'd0) begin
      r = {1'b1, K28_0};
    end else if (pos == POS_LAST) begin
      r = {1'b1, K28_3};
    end else if (mf == 8'd1 && pos == 9'd1) begin
      r = {1'b1, K28_4};
    end else if (mf == 8'd1 && pos >= 9'd2 && pos <= 9'd15) begin
      idx = int'(pos) - 2;
      r   = {1'b0, cfg[8*idx +: 8]};
    end
    return r;
  endfunction

  lmfc_counter #(
    .F (F),
    .K (K)
  ) u_lmfc (
    .clk_i         (clk),
    .rst_i         (rst),
    .frame_cnt_o   (frame_cnt),
    .mf_pos_next_o (mf_pos_next),
    .last_o        (last_oct),
    .lmfc_o        (lmfc)
  );

  // Link state sequencing, SYNC~ low counting and de-assertion frame capture
  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    low_d     = low_q;
    ila_mf_d  = ila_mf_q;
    nofr_d    = nofr_q;
    err_d     = 1'b0;
    case (state_q)
      ST_CGS: begin
        low_d     = 8'd0;
        ila_mf_d  = 8'd0;
        pending_d = i_sync_n;
        // First high cycle of a pending start records where SYNC~ rose
        if (i_sync_n && !pending_q) nofr_d = frame_cnt;
        // ILAS may only start on a multiframe boundary
        if (i_sync_n && last_oct) state_d = ST_ILAS;
      end
      ST_ILAS, ST_DATA: begin
        pending_d = 1'b0;
        if (i_sync_n) begin
          low_d = 8'd0;
          // A low pulse too short to be a resync request is an error report
          if (low_q != 8'd0 && low_q < LOW_THR) err_d = 1'b1;
        end else if (low_q != 8'hFF) begin
          low_d = low_q + 8'd1;
        end
        if (state_q == ST_ILAS && last_oct) begin
          if (ila_mf_q == ILA_LAST) begin
            state_d  = ST_DATA;
            ila_mf_d = 8'd0;
          end else begin
            ila_mf_d = ila_mf_q + 8'd1;
          end
        end
        // Resync request overrides any ILAS -> DATA progression
        if (!i_sync_n && low_d >= LOW_THR) begin
          state_d  = ST_CGS;
          ila_mf_d = 8'd0;
        end
      end
      default: state_d = ST_CGS;
    endcase
  end

  // Stream select and ILA octet for the state and position of the next cycle
  always_comb begin
    mux_d = MUX_KSEQ;
    vld_d = 1'b0;
    ila_d = 9'd0;
    case (state_d)
      ST_ILAS: begin
        mux_d = MUX_ILA;
        vld_d = 1'b1;
        ila_d = ila_octet(mf_pos_next, ila_mf_d, i_cfg);
      end
      ST_DATA: mux_d = MUX_USER;
      default: mux_d = MUX_KSEQ;
    endcase
  end

  // Control and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_CGS;
      pending_q <= 1'b0;
      low_q     <= 8'd0;
      ila_mf_q  <= 8'd0;
      nofr_q    <= 5'd0;
      err_q     <= 1'b0;
      mux_q     <= MUX_KSEQ;
      vld_q     <= 1'b0;
      data_q    <= 8'd0;
      k_q       <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      low_q     <= low_d;
      ila_mf_q  <= ila_mf_d;
      nofr_q    <= nofr_d;
      err_q     <= err_d;
      mux_q     <= mux_d;
      vld_q     <= vld_d;
      data_q    <= ila_d[7:0];
      k_q       <= ila_d[8];
    end
  end

  assign o_state                 = state_q;
  assign o_link_mux              = mux_q;
  assign o_ila_vld               = vld_q;
  assign o_ila_data              = data_q;
  assign o_ila_k                 = k_q;
  assign o_no_frame_de_assertion = nofr_q;
  assign o_lmfc                  = lmfc;
  assign o_sync_err              = err_q;

endmodule

// File: tb/tb_tx_link_ctrl.sv
// Bench for tx_link_ctrl: a time-based reference model for the F=1/K=32
// instance, an ILA content table, and hand sequences on an F=2/K=16 instance.
module tb_tx_link_ctrl;

  localparam int F1 = 1, K1 = 32, FK1 = 32, THR1 = 5, ILA_MF = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         sync1 = 1'b0, sync2 = 1'b0;
  logic [111:0] cfg;
  logic [7:0]   cfg_oct [14];

  logic [2:0] mux1, mux2;
  logic [7:0] data1, data2;
  logic       vld1, vld2, k1, k2, lmfc1, lmfc2, err1, err2;
  logic [4:0] nofr1, nofr2;
  logic [1:0] st1, st2;
  logic [21:0] act1, act2;

  assign act1 = {st1, mux1, vld1, k1, data1, nofr1, lmfc1, err1};
  assign act2 = {st2, mux2, vld2, k2, data2, nofr2, lmfc2, err2};

  int n_chk = 0, n_fail = 0;

  // reference model state
  int       t, link_start, low_run;
  bit       prev_high;
  logic [4:0] m_nofr;
  logic     m_err;

  tx_link_ctrl #(.F(1), .K(32), .ILA_MF(4), .SYNC_REQ_FRAMES(5)) u_dut1 (
    .clk(clk), .rst(rst), .i_sync_n(sync1), .i_cfg(cfg),
    .o_link_mux(mux1), .o_ila_data(data1), .o_ila_vld(vld1), .o_ila_k(k1),
    .o_no_frame_de_assertion(nofr1), .o_lmfc(lmfc1), .o_sync_err(err1), .o_state(st1));

  tx_link_ctrl #(.F(2), .K(16), .ILA_MF(4), .SYNC_REQ_FRAMES(5)) u_dut2 (
    .clk(clk), .rst(rst), .i_sync_n(sync2), .i_cfg(cfg),
    .o_link_mux(mux2), .o_ila_data(data2), .o_ila_vld(vld2), .o_ila_k(k2),
    .o_no_frame_de_assertion(nofr2), .o_lmfc(lmfc2), .o_sync_err(err2), .o_state(st2));

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0d)", name, act, exp, t);
    end
  endtask

  task automatic model_reset();
    t = 0; link_start = -1; low_run = 0; prev_high = 0; m_nofr = 5'd0; m_err = 1'b0;
  endtask

  // Expected outputs derived from time since ILAS start
  task automatic check_model();
    int el, pos, mf;
    logic [1:0] st; logic [2:0] mx; logic v, k, lm; logic [7:0] d;
    st = 2'd0; mx = 3'd1; v = 1'b0; k = 1'b0; d = 8'd0;
    if (link_start >= 0) begin
      el = t - link_start;
      if (el < ILA_MF * FK1) begin
        st = 2'd1; mx = 3'd2; v = 1'b1;
        pos = el % FK1; mf = el / FK1;
        if (pos == 0) begin d = 8'h1C; k = 1'b1; end
        else if (pos == FK1 - 1) begin d = 8'h7C; k = 1'b1; end
        else if (mf == 1 && pos == 1) begin d = 8'h9C; k = 1'b1; end
        else if (mf == 1 && pos >= 2 && pos <= 15) d = cfg_oct[pos-2];
        else d = 8'(pos);
      end else begin
        st = 2'd2; mx = 3'd0;
      end
    end
    lm = (t > 0) && (t % FK1 == 0);
    chk("model", 32'(act1), 32'({st, mx, v, k, d, m_nofr, lm, m_err}));
  endtask

  task automatic model_update(input logic s);
    logic e;
    e = 1'b0;
    if (link_start < 0) begin
      low_run = 0;
      if (s && !prev_high) m_nofr = 5'((t % FK1) / F1);
      prev_high = s;
      if (s && (t % FK1) == FK1 - 1) link_start = t + 1;
    end else begin
      prev_high = 0;
      if (s) begin
        if (low_run >= 1 && low_run < THR1) e = 1'b1;
        low_run = 0;
      end else begin
        low_run++;
        if (low_run >= THR1) begin link_start = -1; low_run = 0; end
      end
    end
    m_err = e;
    t++;
  endtask

  // One clock: check this cycle, drive SYNC~ for it, advance to next negedge
  task automatic cyc(input logic s1, input logic s2);
    check_model();
    sync1 = s1; sync2 = s2;
    model_update(s1);
    @(negedge clk);
  endtask

  task automatic do_reset(input int n, input logic s);
    rst = 1'b1; sync1 = s; sync2 = s;
    @(negedge clk);
    chk("reset_vals", 32'(act1), 32'({2'd0, 3'd1, 1'b0, 1'b0, 8'd0, 5'd0, 1'b0, 1'b0}));
    repeat (n - 1) @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  typedef struct {
    logic       sync;
    int         el;
    logic [1:0] st;
    logic [2:0] mux;
    logic       vld;
    logic       k;
    logic [7:0] d;
  } vec_t;

  vec_t tbl [16];

  initial begin
    int lcnt, t_r, ilas_start;
    for (int n = 0; n < 14; n++) begin
      cfg_oct[n] = 8'(8'hA0 + n);
      cfg[8*n +: 8] = cfg_oct[n];
    end
    tbl[0]  = '{1'b1,   0, 2'd1, 3'd2, 1'b1, 1'b1, 8'h1C};
    tbl[1]  = '{1'b1,   1, 2'd1, 3'd2, 1'b1, 1'b0, 8'h01};
    tbl[2]  = '{1'b1,   5, 2'd1, 3'd2, 1'b1, 1'b0, 8'h05};
    tbl[3]  = '{1'b1,  31, 2'd1, 3'd2, 1'b1, 1'b1, 8'h7C};
    tbl[4]  = '{1'b1,  32, 2'd1, 3'd2, 1'b1, 1'b1, 8'h1C};
    tbl[5]  = '{1'b1,  33, 2'd1, 3'd2, 1'b1, 1'b1, 8'h9C};
    tbl[6]  = '{1'b1,  34, 2'd1, 3'd2, 1'b1, 1'b0, 8'hA0};
    tbl[7]  = '{1'b1,  40, 2'd1, 3'd2, 1'b1, 1'b0, 8'hA6};
    tbl[8]  = '{1'b1,  47, 2'd1, 3'd2, 1'b1, 1'b0, 8'hAD};
    tbl[9]  = '{1'b1,  48, 2'd1, 3'd2, 1'b1, 1'b0, 8'h10};
    tbl[10] = '{1'b1,  63, 2'd1, 3'd2, 1'b1, 1'b1, 8'h7C};
    tbl[11] = '{1'b1,  64, 2'd1, 3'd2, 1'b1, 1'b1, 8'h1C};
    tbl[12] = '{1'b1,  65, 2'd1, 3'd2, 1'b1, 1'b0, 8'h01};
    tbl[13] = '{1'b1,  66, 2'd1, 3'd2, 1'b1, 1'b0, 8'h02};
    tbl[14] = '{1'b1, 127, 2'd1, 3'd2, 1'b1, 1'b1, 8'h7C};
    tbl[15] = '{1'b1, 128, 2'd2, 3'd0, 1'b0, 1'b0, 8'h00};

    model_reset();
    do_reset(3, 1'b0);

    // SYNC~ held low: CGS with LMFC every 32 cycles
    lcnt = 0;
    for (int i = 0; i < 100; i++) begin
      if (lmfc1) lcnt++;
      cyc(1'b0, 1'b1);
    end
    chk("lmfc_count", 32'(lcnt), 32'd3);

    // SYNC~ rises at frame 7; ILAS starts 25 cycles later
    while (t % FK1 != 7) cyc(1'b0, 1'b1);
    t_r = t;
    cyc(1'b1, 1'b1);
    chk("nofr_capture", 32'(nofr1), 32'd7);
    repeat (23) cyc(1'b1, 1'b1);
    chk("cgs_before_ilas", 32'(st1), 32'd0);
    cyc(1'b1, 1'b1);
    chk("ilas_latency", 32'(t - t_r), 32'd25);
    chk("ilas_first", 32'({st1, mux1, k1, data1}), 32'({2'd1, 3'd2, 1'b1, 8'h1C}));

    // ILA content table
    ilas_start = t;
    for (int i = 0; i < 16; i++) begin
      while ((t - ilas_start) < tbl[i].el) cyc(tbl[i].sync, 1'b1);
      chk($sformatf("ila_tbl[%0d]", i), 32'({st1, mux1, vld1, k1, data1}),
          32'({tbl[i].st, tbl[i].mux, tbl[i].vld, tbl[i].k, tbl[i].d}));
    end

    // F=2 instance: short low pulse, then a 10-cycle resync request
    chk("d2_in_data", 32'(st2), 32'd2);
    repeat (3) cyc(1'b1, 1'b0);
    chk("d2_err_idle", 32'({st2, err2}), 32'({2'd2, 1'b0}));
    cyc(1'b1, 1'b1);
    chk("d2_err_pulse", 32'({st2, err2}), 32'({2'd2, 1'b1}));
    cyc(1'b1, 1'b1);
    chk("d2_err_single", 32'({st2, err2}), 32'({2'd2, 1'b0}));
    repeat (5) cyc(1'b1, 1'b1);
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("d2_hold[%0d]", i), 32'({st2, mux2}), 32'({2'd2, 3'd0}));
      cyc(1'b1, 1'b0);
    end
    chk("d2_resync", 32'(act2),
        32'({2'd0, 3'd1, 1'b0, 1'b0, 8'd0, 5'd0, logic'(t % 32 == 0), 1'b0}));

    // Reset during ILA multiframe 2; re-entry waits for a fresh boundary
    do_reset(3, 1'b1);
    while (t < 100) cyc(1'b1, 1'b1);
    chk("in_ila_mf2", 32'({st1, mux1}), 32'({2'd1, 3'd2}));
    do_reset(2, 1'b1);
    while (t < 31) cyc(1'b1, 1'b1);
    chk("reentry_wait", 32'(st1), 32'd0);
    cyc(1'b1, 1'b1);
    chk("reentry_ilas", 32'({st1, k1, data1}), 32'({2'd1, 1'b1, 8'h1C}));

    // SYNC~ falls on the last ILAS octet: DATA is entered and low counting continues
    while (t < 159) cyc(1'b1, 1'b1);
    cyc(1'b0, 1'b1);
    chk("ilas_to_data_low", 32'(st1), 32'd2);
    repeat (4) cyc(1'b0, 1'b1);
    chk("resync_after_transition", 32'(st1), 32'd0);

    // Randomised SYNC~ activity against the model
    for (int r = 0; r < 60; r++) begin
      int hl, ll;
      hl = $urandom_range(10, 120);
      ll = $urandom_range(1, 8);
      if ($urandom_range(0, 15) == 0) do_reset(2, 1'b1);
      repeat (hl) cyc(1'b1, 1'b1);
      repeat (ll) cyc(1'b0, 1'b1);
    end
    check_model();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
